// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, fixed-latency memory between instruction fetch and data access.
// Define MEM_ARB_STATS_EN to add grant and conflict statistics counters as extra output ports.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned MAX_STREAK  = 3
) (
    input  logic        clk,
    input  logic        start_up,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] if_grant_cnt,
    output logic [31:0] d_grant_cnt,
    output logic [31:0] conflict_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    localparam logic [3:0] LatInit   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] StreakMax = 4'(MAX_STREAK);

    state_e      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic [3:0]  streak_q, streak_d;
    logic        owner_fetch_q, owner_fetch_d;

    logic        if_gnt_q, if_gnt_d;
    logic        d_gnt_q, d_gnt_d;
    logic        if_valid_q, if_valid_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        pick_fetch;

    // Fetch wins when it is alone, or when data has used up its streak allowance.
    assign pick_fetch = if_req && (!d_req || (streak_q == StreakMax));

    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        streak_d      = streak_q;
        owner_fetch_d = owner_fetch_q;
        if_gnt_d      = 1'b0;
        d_gnt_d       = 1'b0;
        if_valid_d    = 1'b0;
        d_valid_d     = 1'b0;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        mem_en_d      = mem_en_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (!if_req) begin
                    streak_d = 4'd0;
                end
                if (if_req || d_req) begin
                    state_d  = StAccess;
                    lat_d    = LatInit;
                    mem_en_d = 1'b1;
                    if (pick_fetch) begin
                        if_gnt_d      = 1'b1;
                        owner_fetch_d = 1'b1;
                        mem_we_d      = 1'b0;
                        mem_addr_d    = if_addr;
                        mem_wdata_d   = 32'h0;
                        streak_d      = 4'd0;
                    end else begin
                        d_gnt_d       = 1'b1;
                        owner_fetch_d = 1'b0;
                        mem_we_d      = d_we;
                        mem_addr_d    = d_addr;
                        mem_wdata_d   = d_we ? d_wdata : 32'h0;
                        if (if_req && (streak_q != StreakMax)) begin
                            streak_d = streak_q + 4'd1;
                        end
                    end
                end
            end
            StAccess: begin
                if (lat_q == 4'd0) begin
                    state_d  = StIdle;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (owner_fetch_q) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        // Stores complete without touching the load data register.
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (start_up) begin
            state_q       <= StIdle;
            lat_q         <= 4'd0;
            streak_q      <= 4'd0;
            owner_fetch_q <= 1'b0;
            if_gnt_q      <= 1'b0;
            d_gnt_q       <= 1'b0;
            if_valid_q    <= 1'b0;
            d_valid_q     <= 1'b0;
            if_rdata_q    <= 32'h0;
            d_rdata_q     <= 32'h0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_wdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            lat_q         <= lat_d;
            streak_q      <= streak_d;
            owner_fetch_q <= owner_fetch_d;
            if_gnt_q      <= if_gnt_d;
            d_gnt_q       <= d_gnt_d;
            if_valid_q    <= if_valid_d;
            d_valid_q     <= d_valid_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] if_grant_cnt_q;
    logic [31:0] d_grant_cnt_q;
    logic [31:0] conflict_cnt_q;
    logic        conflict;

    assign conflict = (state_q == StIdle) && if_req && d_req;

    always_ff @(posedge clk) begin
        if (start_up) begin
            if_grant_cnt_q <= 32'h0;
            d_grant_cnt_q  <= 32'h0;
            conflict_cnt_q <= 32'h0;
        end else begin
            if (if_gnt_d) begin
                if_grant_cnt_q <= if_grant_cnt_q + 32'd1;
            end
            if (d_gnt_d) begin
                d_grant_cnt_q <= d_grant_cnt_q + 32'd1;
            end
            if (conflict) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign if_grant_cnt = if_grant_cnt_q;
    assign d_grant_cnt  = d_grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expectations, a monitor checks them.
// Stats counters are checked too when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

    localparam int unsigned Lat    = 2;
    localparam int unsigned Streak = 3;

    logic        clk = 1'b0;
    logic        start_up;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] if_grant_cnt;
    logic [31:0] d_grant_cnt;
    logic [31:0] conflict_cnt;
`endif

    mem_port_arbiter #(
        .MEM_LATENCY(Lat),
        .MAX_STREAK (Streak)
    ) dut (
        .clk      (clk),
        .start_up (start_up),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_valid  (d_valid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .if_grant_cnt(if_grant_cnt),
        .d_grant_cnt (d_grant_cnt),
        .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: read data presented while a read access is enabled.
    logic [31:0] mem [0:255];
    assign mem_rdata = (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end
    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[8'h01] <= 32'h8C22_0000;
        mem[8'h80] <= 32'h0BAD_F00D;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Requesters: main issues requests by count; req drops in the grant cycle and re-raises after.
    int   if_issued = 0, if_served = 0, d_issued = 0, d_served = 0;
    logic if_gap = 1'b0, d_gap = 1'b0;
    assign if_req = (if_issued > if_served) && !if_gap;
    assign d_req  = (d_issued > d_served) && !d_gap;

    always @(posedge clk) begin
        #1;
        if_gap = 1'b0;
        d_gap  = 1'b0;
        if (if_gnt) begin if_served++; if_gap = 1'b1; end
        if (d_gnt)  begin d_served++;  d_gap  = 1'b1; end
    end

    typedef struct {
        logic        fetch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        abort;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    logic        infl_v = 1'b0;
    int          ncyc = 0;
    int          due = 0;
    int          gnt_total = 0;
    logic [31:0] m_if = 32'h0;
    logic [31:0] m_d = 32'h0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        ncyc++;
        if (start_up) begin
            m_if   = 32'h0;
            m_d    = 32'h0;
            infl_v = 1'b0;
        end else begin
            if (if_valid || d_valid) begin
                if (!infl_v) chk("spurious_valid", {30'b0, if_valid, d_valid}, 32'h0);
                else chk("valid_cycle", ncyc, due);
            end
            if (infl_v && ncyc == due) begin
                chk("valid_port", {30'b0, if_valid, d_valid}, cur.fetch ? 32'h2 : 32'h1);
                chk("done_mem_en", {31'b0, mem_en}, 32'h0);
                chk("done_mem_we", {31'b0, mem_we}, 32'h0);
                if (cur.fetch) m_if = cur.rdata;
                else if (!cur.we) m_d = cur.rdata;
                infl_v = 1'b0;
            end
            if (infl_v && ncyc < due) begin
                chk("hold_mem_en", {31'b0, mem_en}, 32'h1);
                chk("hold_mem_addr", mem_addr, cur.addr);
            end
            if (if_gnt || d_gnt) begin
                if (expq.size() == 0) begin
                    chk("spurious_gnt", {30'b0, if_gnt, d_gnt}, 32'h0);
                end else begin
                    e = expq.pop_front();
                    chk("gnt_port", {30'b0, if_gnt, d_gnt}, e.fetch ? 32'h2 : 32'h1);
                    chk("gnt_mem_en", {31'b0, mem_en}, 32'h1);
                    chk("gnt_mem_we", {31'b0, mem_we}, {31'b0, e.we});
                    chk("gnt_mem_addr", mem_addr, e.addr);
                    chk("gnt_mem_wdata", mem_wdata, e.wdata);
                    gnt_total++;
                    if (!e.abort) begin
                        cur    = e;
                        infl_v = 1'b1;
                        due    = ncyc + int'(Lat);
                    end
                end
            end
            chk("if_rdata", if_rdata, m_if);
            chk("d_rdata", d_rdata, m_d);
        end
    end

    task automatic push(input logic fetch, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input logic abort);
        exp_t e;
        e.fetch = fetch; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        e.abort = abort;
        expq.push_back(e);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while (n < 200 && (expq.size() != 0 || infl_v || if_req || d_req)) begin
            @(negedge clk);
            n++;
        end
        chk("quiet_timeout", {31'b0, n < 200}, 32'h1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        int n;
        start_up = 1'b1;
        if_addr  = 32'h4;
        d_we     = 1'b0;
        d_addr   = 32'h200;
        d_wdata  = 32'h0;

        // Reset held with both requests pending; data wins first, then fetch.
        push(1'b0, 1'b0, 32'h200, 32'h0, 32'h0BAD_F00D, 1'b0);
        push(1'b1, 1'b0, 32'h4, 32'h0, 32'h8C22_0000, 1'b0);
        if_issued = 1;
        d_issued  = 1;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {26'b0, if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we}, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        chk("reset_if_rdata", if_rdata, 32'h0);
        chk("reset_d_rdata", d_rdata, 32'h0);
        start_up = 1'b0;
        wait_quiet();

        // Single fetch.
        push(1'b1, 1'b0, 32'h4, 32'h0, 32'h8C22_0000, 1'b0);
        if_issued++;
        wait_quiet();

        // Store then load back; load's stale d_wdata must not reach the memory.
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        push(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0);
        d_issued++;
        wait_quiet();
        d_we = 1'b0; d_wdata = 32'h1234_5678;
        push(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);
        d_issued++;
        wait_quiet();

        // Reset in the cycle after the data grant: no completion may follow.
        d_addr = 32'h200;
        push(1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1);
        d_issued++;
        n = 0;
        while (n < 50 && !d_gnt) begin @(negedge clk); n++; end
        chk("abort_gnt_timeout", {31'b0, n < 50}, 32'h1);
        @(negedge clk);
        start_up = 1'b1;
        @(negedge clk);
        chk("abort_mem_en", {31'b0, mem_en}, 32'h0);
        chk("abort_d_valid", {31'b0, d_valid}, 32'h0);
        start_up = 1'b0;
        repeat (Lat + 3) @(negedge clk);
        d_addr = 32'h100;
        push(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);
        d_issued++;
        wait_quiet();

        // Starvation guard: both requesters keep asking.
        start_up = 1'b1;
        @(negedge clk);
        start_up = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) push(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);
            push(1'b1, 1'b0, 32'h4, 32'h0, 32'h8C22_0000, 1'b0);
        end
        base = gnt_total;
        if_issued += 2;
        d_issued  += 7;
        n = 0;
        while (n < 200 && gnt_total < base + 8) begin @(negedge clk); n++; end
        chk("starve_timeout", {31'b0, n < 200}, 32'h1);
`ifdef MEM_ARB_STATS_EN
        chk("if_grant_cnt", if_grant_cnt, 32'd2);
        chk("d_grant_cnt", d_grant_cnt, 32'd6);
        chk("conflict_cnt", conflict_cnt, 32'd8);
`endif
        d_issued = d_served;
        wait_quiet();

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
